// File: rtl/coin_acceptor.sv
// coin_acceptor: sync, debounce and edge-detect two coin sensors, queue coin codes.
// Optional per-code tally counters are built when COIN_TALLY_EN is defined.
module coin_acceptor #(
    parameter int DEB_CYCLES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin5_raw,
    input  logic             coin10_raw,
    output logic [1:0]       x_out,
    output logic             coin_valid,
    output logic             fifo_full,
    output logic             reject
`ifdef COIN_TALLY_EN
    ,
    output logic [CNT_W-1:0] total5,
    output logic [CNT_W-1:0] total10
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

    // bit 0 = 5-unit sensor, bit 1 = 10-unit sensor
    logic [1:0]    s1_q, s1_d, s2_q, s2_d;
    logic [1:0]    deb_q, deb_d, deb_dly_q, deb_dly_d;
    logic [DW-1:0] cnt_q [2];
    logic [DW-1:0] cnt_d [2];
    logic [1:0]    ev;

    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [1:0]    mem_d [FIFO_DEPTH];
    logic          empty, full, pop, push, one_ev;
    logic [1:0]    code;

    logic [1:0]    x_out_q, x_out_d;
    logic          coin_valid_q, coin_valid_d;
    logic          reject_q, reject_d;

    // Pointer MSBs differ only when the write side has lapped the read side.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty;

    // Synchroniser, debounce and rising-edge detection for both sensors
    always_comb begin
        s1_d      = {coin10_raw, coin5_raw};
        s2_d      = s1_q;
        deb_dly_d = deb_q;
        deb_d     = deb_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_MAX) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DW'(1);
                end
            end
        end
        ev = deb_q & ~deb_dly_q;
    end

    // Queue push/reject decision and head drain onto x_out
    always_comb begin
        one_ev       = ev[0] ^ ev[1];
        push         = one_ev && (!full || pop);
        reject_d     = (&ev) || (one_ev && full && !pop);
        code         = ev[0] ? 2'b01 : 2'b10;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        x_out_d      = 2'b00;
        coin_valid_d = 1'b0;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = code;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            x_out_d      = mem_q[rd_ptr_q[AW-1:0]];
            coin_valid_d = 1'b1;
            rd_ptr_d     = rd_ptr_q + 1'b1;
        end
    end

    // State registers; reset flushes the queue and all front-end state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            deb_q        <= '0;
            deb_dly_q    <= '0;
            cnt_q[0]     <= '0;
            cnt_q[1]     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            x_out_q      <= 2'b00;
            coin_valid_q <= 1'b0;
            reject_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            deb_q        <= deb_d;
            deb_dly_q    <= deb_dly_d;
            cnt_q[0]     <= cnt_d[0];
            cnt_q[1]     <= cnt_d[1];
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            x_out_q      <= x_out_d;
            coin_valid_q <= coin_valid_d;
            reject_q     <= reject_d;
            mem_q        <= mem_d;
        end
    end

    assign x_out      = x_out_q;
    assign coin_valid = coin_valid_q;
    assign reject     = reject_q;
    assign fifo_full  = full;

`ifdef COIN_TALLY_EN
    logic [CNT_W-1:0] total5_q, total5_d, total10_q, total10_d;

    // Saturating tallies of accepted coins
    always_comb begin
        total5_d  = total5_q;
        total10_d = total10_q;
        if (push && ev[0] && (total5_q != '1)) begin
            total5_d = total5_q + 1'b1;
        end
        if (push && ev[1] && (total10_q != '1)) begin
            total10_d = total10_q + 1'b1;
        end
    end

    // Tally registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total5_q  <= '0;
            total10_q <= '0;
        end else begin
            total5_q  <= total5_d;
            total10_q <= total10_d;
        end
    end

    assign total5  = total5_q;
    assign total10 = total10_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed checks of coin_acceptor (DEB_CYCLES=4, FIFO_DEPTH=4).
// Tally checks are compiled only when COIN_TALLY_EN is defined.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin5_raw = 1'b0;
    logic       coin10_raw = 1'b0;
    logic [1:0] x_out;
    logic       coin_valid;
    logic       fifo_full;
    logic       reject;
`ifdef COIN_TALLY_EN
    logic [7:0] total5;
    logic [7:0] total10;
`endif

    int total = 0;
    int bad = 0;

    coin_acceptor #(
        .DEB_CYCLES(4),
        .FIFO_DEPTH(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .coin5_raw(coin5_raw),
        .coin10_raw(coin10_raw),
        .x_out(x_out),
        .coin_valid(coin_valid),
        .fifo_full(fifo_full),
        .reject(reject)
`ifdef COIN_TALLY_EN
        ,
        .total5(total5),
        .total10(total10)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n cycles; x_out=code only on cycle 'at', reject only on cycle 'rat'
    task automatic run(input string tag, input int n, input int at,
                       input logic [1:0] code, input int rat);
        for (int i = 1; i <= n; i++) begin
            step();
            chk({tag, "_x"}, 32'(x_out), (i == at) ? 32'(code) : 32'd0);
            chk({tag, "_vld"}, 32'(coin_valid), 32'(i == at));
            chk({tag, "_rej"}, 32'(reject), 32'(i == rat));
        end
    endtask

    // 8 cycles high then 6 low; enough for the debounced level to fall again
    task automatic coin(input string tag, input logic [1:0] sel,
                        input int at, input logic [1:0] code, input int rat);
        coin5_raw  = sel[0];
        coin10_raw = sel[1];
        run(tag, 8, at, code, rat);
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        run({tag, "_lo"}, 6, 0, 2'b00, 0);
    endtask

    logic [1:0] seq [4];

    initial begin
        seq[0] = 2'b01;
        seq[1] = 2'b10;
        seq[2] = 2'b01;
        seq[3] = 2'b10;

        // reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_vld", 32'(coin_valid), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_rej", 32'(reject), 32'd0);
`ifdef COIN_TALLY_EN
        chk("rst_t5", 32'(total5), 32'd0);
        chk("rst_t10", 32'(total10), 32'd0);
`endif
        repeat (3) step();
        rst = 1'b1;
        run("idle", 4, 0, 2'b00, 0);

        // clean 5-unit coin: code on the 8th edge (N+7)
        coin5_raw = 1'b1;
        run("t1", 10, 8, 2'b01, 0);
        coin5_raw = 1'b0;
        run("t1_lo", 12, 0, 2'b00, 0);

        // 10-unit bounce: 3 high, 1 low, then stable
        coin10_raw = 1'b1;
        run("t2_g", 3, 0, 2'b00, 0);
        coin10_raw = 1'b0;
        run("t2_gl", 1, 0, 2'b00, 0);
        coin10_raw = 1'b1;
        run("t2", 20, 8, 2'b10, 0);
        coin10_raw = 1'b0;
        run("t2_lo", 12, 0, 2'b00, 0);

        // both sensors at once: reject, nothing queued
        coin("t3", 2'b11, 0, 2'b00, 7);
        run("t3_idle", 4, 0, 2'b00, 0);

        // fill the queue with pops stalled, 5th coin rejected
        force dut.pop = 1'b0;
        coin("t4_c1", 2'b01, 0, 2'b00, 0);
        coin("t4_c2", 2'b10, 0, 2'b00, 0);
        coin("t4_c3", 2'b01, 0, 2'b00, 0);
        chk("t4_full3", 32'(fifo_full), 32'd0);
        coin("t4_c4", 2'b10, 0, 2'b00, 0);
        chk("t4_full4", 32'(fifo_full), 32'd1);
        coin("t4_c5", 2'b01, 0, 2'b00, 7);
        chk("t4_full5", 32'(fifo_full), 32'd1);
        release dut.pop;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_drain_x", 32'(x_out), 32'(seq[i]));
            chk("t4_drain_vld", 32'(coin_valid), 32'd1);
        end
        step();
        chk("t4_end_x", 32'(x_out), 32'd0);
        chk("t4_end_full", 32'(fifo_full), 32'd0);
        run("t4_idle", 4, 0, 2'b00, 0);

        // async reset with coins still queued
        force dut.pop = 1'b0;
        coin("t5_c1", 2'b01, 0, 2'b00, 0);
        coin("t5_c2", 2'b10, 0, 2'b00, 0);
        coin("t5_c3", 2'b01, 0, 2'b00, 0);
        release dut.pop;
        step();
        chk("t5_head", 32'(x_out), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_x", 32'(x_out), 32'd0);
        chk("t5_rst_vld", 32'(coin_valid), 32'd0);
        chk("t5_rst_full", 32'(fifo_full), 32'd0);
        step();
        step();
        chk("t5_hold_x", 32'(x_out), 32'd0);
        #3 rst = 1'b1;
        run("t5_after", 12, 0, 2'b00, 0);

        // tallies: 3 five, 2 ten, 1 rejected pair, then saturation
        coin("t6_a", 2'b01, 8, 2'b01, 0);
        coin("t6_b", 2'b10, 8, 2'b10, 0);
        coin("t6_c", 2'b01, 8, 2'b01, 0);
        coin("t6_d", 2'b11, 0, 2'b00, 7);
        coin("t6_e", 2'b10, 8, 2'b10, 0);
        coin("t6_f", 2'b01, 8, 2'b01, 0);
`ifdef COIN_TALLY_EN
        chk("t6_t5", 32'(total5), 32'd3);
        chk("t6_t10", 32'(total10), 32'd2);
        for (int k = 0; k < 252; k++) begin
            coin("t6_sat", 2'b01, 8, 2'b01, 0);
        end
        chk("t6_t5_255", 32'(total5), 32'd255);
        coin("t6_over", 2'b01, 8, 2'b01, 0);
        chk("t6_t5_sat", 32'(total5), 32'd255);
        chk("t6_t10_keep", 32'(total10), 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
